// File: rtl/calc_pkg.sv
// Shared types and 7-segment constants for the BCD calculator core.
package calc_pkg;

  typedef enum logic [2:0] {
    ENTRY_A,
    ENTRY_B,
    CALC,
    NEGATE,
    SHOW
  } calc_state_t;

  typedef logic [3:0] bcd_t;

  // Active-low {g,f,e,d,c,b,a} patterns for digits 0..9.
  localparam logic [0:9][6:0] SEG_TABLE = {
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  function automatic logic [6:0] bcd_to_seg(input bcd_t d);
    if (d > 4'd9) return SEG_BLANK;
    return SEG_TABLE[d];
  endfunction

endpackage

// File: rtl/disp_scan.sv
// Time-multiplexed scan of a DIGITS-wide BCD value onto one active-low 7-segment bus.
module disp_scan
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS*4-1:0]   value,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  logic [CW-1:0] cnt;
  logic [IW-1:0] sel;
  logic [IW-1:0] sel_nxt_c;
  logic          wrap_c;

  // Digit advances once the dwell counter expires, wrapping at the MSD.
  always_comb begin
    wrap_c    = (cnt == CW'(SCAN_DIV - 1));
    sel_nxt_c = sel;
    if (wrap_c) sel_nxt_c = (sel == IW'(DIGITS - 1)) ? '0 : sel + 1'b1;
  end

  // Segments follow the selected digit every cycle so value changes show up mid-slot.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
      sel <= '0;
      an  <= ~DIGITS'(1);
      seg <= SEG_TABLE[0];
    end else begin
      cnt <= wrap_c ? '0 : cnt + 1'b1;
      sel <= sel_nxt_c;
      an  <= ~(DIGITS'(1) << sel_nxt_c);
      seg <= bcd_to_seg(value[{sel_nxt_c, 2'b00} +: 4]);
    end
  end

endmodule

// File: rtl/bcd_calc_core.sv
// DIGITS-wide BCD add/subtract calculator: keypad entry, digit-serial arithmetic, scanned display.
module bcd_calc_core
  import calc_pkg::*;
#(
  parameter int unsigned DIGITS   = 4,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [3:0]        entrada,
  input  logic              guardar,
  input  logic              op_sub,
  input  logic              igual,
  input  logic              borrar,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic              busy,
  output logic              ovf,
  output logic              neg
);

  localparam int unsigned W  = DIGITS * 4;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned CW = $clog2(DIGITS + 1);

  calc_state_t   state;
  logic [W-1:0]  entry;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic [W-1:0]  result;
  logic [CW-1:0] count;
  logic [IW-1:0] idx;
  logic          carry;
  logic          sub;

  bcd_t          a_d_c;
  bcd_t          b_d_c;
  bcd_t          r_d_c;
  bcd_t          dig_c;
  logic [4:0]    t_c;
  logic          carry_nxt_c;
  logic          last_c;
  logic          digit_ok_c;
  logic          room_c;
  logic [W-1:0]  disp_c;

  // One BCD digit slice: nine's-complement add in CALC, ten's-complement pass in NEGATE.
  always_comb begin
    a_d_c = a_reg[{idx, 2'b00} +: 4];
    b_d_c = b_reg[{idx, 2'b00} +: 4];
    r_d_c = result[{idx, 2'b00} +: 4];
    if (state == NEGATE) t_c = 5'(4'd9 - r_d_c) + 5'(carry);
    else                 t_c = 5'(a_d_c) + 5'(sub ? 4'(4'd9 - b_d_c) : b_d_c) + 5'(carry);
    carry_nxt_c = (t_c > 5'd9);
    dig_c       = carry_nxt_c ? 4'(t_c - 5'd10) : t_c[3:0];
    last_c      = (idx == IW'(DIGITS - 1));
    digit_ok_c  = (entrada <= 4'd9);
    room_c      = (count < CW'(DIGITS));
    disp_c      = (state == ENTRY_A || state == ENTRY_B) ? entry : result;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= ENTRY_A;
      entry  <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      result <= '0;
      count  <= '0;
      idx    <= '0;
      carry  <= 1'b0;
      sub    <= 1'b0;
      busy   <= 1'b0;
      ovf    <= 1'b0;
      neg    <= 1'b0;
    end else if (borrar && state != CALC && state != NEGATE) begin
      state  <= ENTRY_A;
      entry  <= '0;
      count  <= '0;
      a_reg  <= '0;
      result <= '0;
      ovf    <= 1'b0;
      neg    <= 1'b0;
    end else begin
      case (state)
        ENTRY_A, ENTRY_B: begin
          if (igual && state == ENTRY_B) begin
            b_reg <= entry;
            idx   <= '0;
            carry <= sub;
            busy  <= 1'b1;
            state <= CALC;
          end else if (guardar && state == ENTRY_A) begin
            a_reg <= entry;
            sub   <= op_sub;
            entry <= '0;
            count <= '0;
            state <= ENTRY_B;
          end else if (push && digit_ok_c && room_c) begin
            entry <= {entry[W-5:0], entrada};
            count <= count + 1'b1;
          end
        end
        CALC: begin
          result[{idx, 2'b00} +: 4] <= dig_c;
          carry <= carry_nxt_c;
          if (!last_c) begin
            idx <= idx + 1'b1;
          end else if (!sub || carry_nxt_c) begin
            if (!sub) ovf <= carry_nxt_c;
            neg   <= 1'b0;
            busy  <= 1'b0;
            state <= SHOW;
          end else begin
            // No end-around carry: A < B, so recomplement the magnitude.
            neg   <= 1'b1;
            idx   <= '0;
            carry <= 1'b1;
            state <= NEGATE;
          end
        end
        NEGATE: begin
          result[{idx, 2'b00} +: 4] <= dig_c;
          carry <= carry_nxt_c;
          if (last_c) begin
            busy  <= 1'b0;
            state <= SHOW;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        SHOW: begin
          if (guardar && !ovf && !neg) begin
            a_reg <= result;
            sub   <= op_sub;
            entry <= '0;
            count <= '0;
            state <= ENTRY_B;
          end else if (push && digit_ok_c) begin
            ovf   <= 1'b0;
            neg   <= 1'b0;
            entry <= W'(entrada);
            count <= CW'(1);
            state <= ENTRY_A;
          end
        end
        default: state <= ENTRY_A;
      endcase
    end
  end

  disp_scan #(
    .DIGITS  (DIGITS),
    .SCAN_DIV(SCAN_DIV)
  ) u_disp_scan (
    .clk  (clk),
    .rst  (rst),
    .value(disp_c),
    .seg  (seg),
    .an   (an)
  );

endmodule

// File: tb/tb_bcd_calc_core.sv
// Randomized and directed checks of bcd_calc_core against an integer-arithmetic reference model.
module tb_bcd_calc_core;

  localparam int unsigned D  = 4;
  localparam int unsigned SD = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         push = 1'b0;
  logic [3:0]   entrada = 4'd0;
  logic         guardar = 1'b0;
  logic         op_sub = 1'b0;
  logic         igual = 1'b0;
  logic         borrar = 1'b0;
  logic [6:0]   seg;
  logic [D-1:0] an;
  logic         busy;
  logic         ovf;
  logic         neg;

  int checks = 0;
  int errors = 0;
  int last_disp = 0;
  int last_ovf  = 0;
  int last_neg  = 0;

  bcd_calc_core #(.DIGITS(D), .SCAN_DIV(SD)) dut (
    .clk(clk), .rst(rst), .push(push), .entrada(entrada), .guardar(guardar),
    .op_sub(op_sub), .igual(igual), .borrar(borrar), .seg(seg), .an(an),
    .busy(busy), .ovf(ovf), .neg(neg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int p10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [6:0] exp_seg(input int d);
    case (d)
      0: return 7'b1000000;  1: return 7'b1111001;  2: return 7'b0100100;
      3: return 7'b0110000;  4: return 7'b0011001;  5: return 7'b0010010;
      6: return 7'b0000010;  7: return 7'b1111000;  8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction

  // One clock of stimulus, launched and retired on falling edges.
  task automatic drive(input logic p, input int d, input logic g, input logic os,
                       input logic i, input logic b);
    push = p; entrada = 4'(d); guardar = g; op_sub = os; igual = i; borrar = b;
    @(negedge clk);
    push = 1'b0; guardar = 1'b0; igual = 1'b0; borrar = 1'b0;
  endtask

  task automatic key(input int d);
    drive(1'b1, d, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic enter_num(input int v);
    for (int i = D - 1; i >= 0; i--) key((v / p10(i)) % 10);
  endtask

  task automatic check_disp(input string tag, input int val);
    logic [D-1:0] want;
    int n;
    repeat (2) @(negedge clk);
    for (int k = 0; k < int'(D); k++) begin
      want = ~(D'(1) << k);
      n = 0;
      while (an !== want && n < int'(4 * D * SD)) begin
        @(negedge clk);
        n++;
      end
      chk({tag, "_an"}, 32'(an), 32'(want));
      chk({tag, "_seg"}, 32'(seg), 32'(exp_seg((val / p10(k)) % 10)));
    end
  endtask

  // Operand A already stored: key B, press igual, compare against plain arithmetic.
  task automatic do_calc(input string tag, input int a, input int b, input int s);
    int lim, edisp, eovf, eneg, ebusy, n;
    lim = p10(D);
    if (s == 0) begin
      edisp = (a + b) % lim; eovf = (a + b >= lim) ? 1 : 0; eneg = 0; ebusy = D;
    end else begin
      eovf = 0; eneg = (a < b) ? 1 : 0;
      edisp = (a >= b) ? a - b : b - a;
      ebusy = eneg ? 2 * D : D;
    end
    enter_num(b);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk({tag, "_busy_len"}, 32'(n), 32'(ebusy));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eovf));
    chk({tag, "_neg"}, 32'(neg), 32'(eneg));
    check_disp(tag, edisp);
    last_disp = edisp; last_ovf = eovf; last_neg = eneg;
  endtask

  task automatic run_calc(input string tag, input int a, input int b, input int s);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    enter_num(a);
    drive(1'b0, 0, 1'b1, 1'(s), 1'b0, 1'b0);
    do_calc(tag, a, b, s);
  endtask

  task automatic chain(input string tag, input int b, input int s);
    drive(1'b0, 0, 1'b1, 1'(s), 1'b0, 1'b0);
    do_calc(tag, last_disp, b, s);
  endtask

  initial begin
    int a, b, s, n;

    // Reset state, held and then released
    repeat (3) @(negedge clk);
    chk("rst_seg", 32'(seg), 32'h40);
    chk("rst_an", 32'(an), 32'hE);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_neg", 32'(neg), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rel_seg", 32'(seg), 32'h40);
    chk("rel_an", 32'(an), 32'hE);

    // Entry limits: fifth digit and non-BCD digit dropped
    for (int i = 1; i <= 5; i++) key(i);
    key(10);
    check_disp("entry_limit", 1234);

    // Add and chaining
    run_calc("add", 1234, 999, 0);
    chain("chain", 1, 0);

    // Overflow; guardar in SHOW must not start a new operation
    run_calc("ovf", 9999, 1, 0);
    drive(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("ovf_hold_busy", 32'(busy), 32'd0);
    chk("ovf_hold_ovf", 32'(ovf), 32'd1);
    check_disp("ovf_hold", 0);

    // borrar wins over push in the same cycle
    drive(1'b1, 7, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("clr_ovf", 32'(ovf), 32'd0);
    check_disp("clr_push", 0);
    enter_num(5678);
    check_disp("clr_entry", 5678);

    // Subtract, negative and non-negative
    run_calc("sub_neg", 100, 250, 1);
    run_calc("sub_pos", 250, 100, 1);

    // igual during CALC ignored
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    enter_num(1234);
    drive(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    enter_num(1111);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    n = 1;
    while (busy === 1'b1 && n < 100) begin
      n++;
      @(negedge clk);
    end
    chk("igual_calc_busy_len", 32'(n), 32'(D));
    check_disp("igual_calc", 2345);

    // Reset during the second CALC cycle
    drive(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b1);
    enter_num(1234);
    drive(1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0);
    enter_num(5678);
    drive(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("mid_busy_pre", 32'(busy), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_ovf", 32'(ovf), 32'd0);
    chk("mid_neg", 32'(neg), 32'd0);
    chk("mid_an", 32'(an), 32'hE);
    chk("mid_seg", 32'(seg), 32'h40);
    rst = 1'b1;
    @(negedge clk);
    key(3);
    chk("mid_after_busy", 32'(busy), 32'd0);
    check_disp("mid_after", 3);

    // Randomized operations with occasional chaining
    for (int it = 0; it < 24; it++) begin
      a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(9000, 9999)) : int'($urandom_range(0, 9999));
      b = int'($urandom_range(0, 9999));
      s = int'($urandom_range(0, 1));
      run_calc("rnd", a, b, s);
      if (last_ovf == 0 && last_neg == 0 && $urandom_range(0, 1) == 1)
        chain("rnd_chain", int'($urandom_range(0, 9999)), int'($urandom_range(0, 1)));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_calc_core.md
# bcd_calc_core

Parametrised successor of the keypad adder: a DIGITS-wide BCD calculator core with digit entry, operand store, add/subtract with sign and overflow, result chaining, and a time-multiplexed 7-segment scan driving all digits. It sits between the debounced keypad/button front-end and the board's multiplexed display. It replaces the single-digit display path of the current adder.

## Interface
- DIGITS, 4: number of BCD digits per operand, result and display (2..8).
- SCAN_DIV, 50000: clk cycles each display digit is lit (≥2).
- clk  in  1  system clock, all logic rising-edge.
- rst  in  1  asynchronous, active-low reset.
- push  in  1  one-cycle pulse: enter digit on `entrada`.
- entrada  in  4  BCD digit; values >9 ignored.
- guardar  in  1  one-cycle pulse: store entry as operand A, latch `op_sub`.
- op_sub  in  1  0 = add, 1 = subtract; sampled only with `guardar`.
- igual  in  1  one-cycle pulse: compute A op B.
- borrar  in  1  one-cycle pulse: full clear to entry of A.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an  out  DIGITS  digit enables, active-low, one-hot-low; bit 0 = least-significant digit.
- busy  out  1  high while computing.
- ovf  out  1  sticky add overflow for the shown result.
- neg  out  1  shown result is negative (magnitude on display).

## Operation
- States: ENTRY_A, ENTRY_B, CALC, NEGATE, SHOW.
- Priority of same-cycle inputs: borrar > igual > guardar > push.
- borrar (any state except CALC/NEGATE): clear entry, count, A, result, ovf, neg; go ENTRY_A.
- push in ENTRY_A/ENTRY_B:
  - Requires entrada ≤ 9 and count < DIGITS.
  - entry ← {entry[DIGITS-2:0], entrada}; count++.
  - Otherwise ignored.
- guardar in ENTRY_A: A ← entry, sub ← op_sub, entry/count ← 0, go ENTRY_B. Ignored in ENTRY_B.
- igual in ENTRY_B: B ← entry, idx ← 0, carry ← sub, busy ← 1, go CALC. Ignored elsewhere.
- CALC, one digit per cycle, LSD first:
  - t = A[idx] + (sub ? 9−B[idx] : B[idx]) + carry.
  - If t > 9: digit t−10, carry 1; else digit t, carry 0.
  - After digit DIGITS−1:
    - add: ovf ← carry.
    - sub, carry = 1: result non-negative, neg ← 0.
    - sub, carry = 0: neg ← 1, go NEGATE.
  - Otherwise go SHOW.
- NEGATE: ten's complement of result, one digit per cycle (9−r[idx] + carry, carry init 1), DIGITS cycles, then SHOW.
- SHOW, busy = 0, display shows result:
  - push (valid digit): clear ovf/neg, entry ← {0…,entrada}, count ← 1, go ENTRY_A.
  - guardar with ovf = 0 and neg = 0: A ← result, sub ← op_sub, go ENTRY_B (chaining). Ignored otherwise.
- All inputs ignored in CALC/NEGATE.
- Display source: entry in ENTRY_A/ENTRY_B; result in CALC/NEGATE/SHOW. Leading zeros are shown.

## Timing
- Reset values:
  - state ENTRY_A; entry, A, B, result, count, idx all 0.
  - busy 0, ovf 0, neg 0.
  - scan idx 0, scan counter 0; an = ~1 (digit 0 lit); seg = 7'b1000000 ('0').
- Entry register updates on the cycle after push. seg/an are registered; the new digit value appears by the next scan slot of that digit.
- busy rises the cycle after igual.
- Compute latency: DIGITS cycles (add, or sub non-negative); 2·DIGITS cycles (sub negative). busy falls with the entry into SHOW.
- Scan:
  - Counter runs 0..SCAN_DIV−1, then the scan index advances, wrapping DIGITS−1 → 0.
  - an and seg change on the same edge; no overlap or blank cycle is required.
- Reset asserted mid-CALC/NEGATE aborts immediately to reset values; no partial result is retained.

## Structure
- Package calc_pkg holds:
  - state enum `calc_state_t`;
  - `bcd_t` (logic [3:0]);
  - 7-segment active-low constant table for 0–9;
  - a blank code for values >9.
- One sub-module: `disp_scan` (parameters DIGITS, SCAN_DIV). It contains the scan counter, digit select, BCD→seg decode, and registered seg/an.
- Arithmetic and FSM stay in bcd_calc_core.

## Test plan
- Reset (DIGITS=4): hold rst low → seg=7'b1000000, an=4'b1110, busy=0, ovf=0, neg=0; held through rst release.
- Entry limits: push 1,2,3,4,5 then entrada=4'hA → entry=1234; 5 and A ignored; scanned digits show 4,3,2,1 on an bits 0..3.
- Add: 1234 guardar(op_sub=0), 0999 igual → busy high exactly 4 cycles, result 2233, ovf=0; then guardar + 0001 igual → 2234.
- Overflow: 9999 + 0001 → result 0000, ovf=1; guardar in SHOW ignored (state stays SHOW).
- Subtract: 0100 − 0250 → busy 8 cycles, display 0150, neg=1; 0250 − 0100 → 0150, neg=0, busy 4 cycles.
- Boundaries:
  - borrar and push in the same cycle → cleared, push dropped.
  - rst low during cycle 2 of CALC → reset values next cycle.
  - igual during CALC ignored.
